// File: rtl/servo_pwm.sv
// Hobby-servo PWM generator: fixed frame, pulse width picked by a 2-bit
// position select that is only adopted at frame boundaries.
module servo_pwm #(
    parameter int FRAME_CYCLES = 2_000_000,
    parameter int PW_1MS       = 100_000,
    parameter int PW_1P5MS     = 150_000,
    parameter int PW_2MS       = 200_000,
    parameter int CNT_W        = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pos,
    output logic       _control
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] W_1MS    = CNT_W'(PW_1MS);
    localparam logic [CNT_W-1:0] W_1P5MS  = CNT_W'(PW_1P5MS);
    localparam logic [CNT_W-1:0] W_2MS    = CNT_W'(PW_2MS);

    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wid_q, wid_d;
    logic [CNT_W-1:0] wid_sel;
    logic             ctrl_q, ctrl_d;

    always_comb begin
        wid_sel = W_1P5MS;
        case (sync2_q)
            2'b00:   wid_sel = W_1MS;
            2'b10:   wid_sel = W_2MS;
            default: wid_sel = W_1P5MS;
        endcase
    end

    // Width is latched on the last cycle so a frame never changes mid-pulse.
    always_comb begin
        sync1_d = pos;
        sync2_d = sync1_q;
        cnt_d   = cnt_q + CNT_ONE;
        wid_d   = wid_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            wid_d = wid_sel;
        end
        ctrl_d = (cnt_q < wid_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 2'b01;
            sync2_q <= 2'b01;
            cnt_q   <= '0;
            wid_q   <= W_1P5MS;
            ctrl_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            wid_q   <= wid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign _control = ctrl_q;

endmodule

// File: tb/tb_servo_pwm.sv
// Scoreboard bench for servo_pwm on a scaled-down frame: expected pulse
// widths are queued ahead of each frame and popped on every falling edge.
module tb_servo_pwm;

    localparam int F   = 1000;
    localparam int P1  = 50;
    localparam int P15 = 75;
    localparam int P2  = 100;
    localparam int CW  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pos;
    logic       ctrl;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    logic m_prev = 1'b0;
    logic m_have = 1'b0;
    int   m_hi   = 0;
    int   m_per  = 0;

    servo_pwm #(
        .FRAME_CYCLES(F),
        .PW_1MS(P1),
        .PW_1P5MS(P15),
        .PW_2MS(P2),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pos(pos),
        ._control(ctrl)
    );

    always #5 clk = ~clk;

    function automatic int exp_w(input logic [1:0] p);
        case (p)
            2'b00:   return P1;
            2'b10:   return P2;
            default: return P15;
        endcase
    endfunction

    // Measures every pulse and period, and compares widths with the queue.
    always @(negedge clk) begin
        int e;
        if (!rst_n) begin
            m_prev = 1'b0;
            m_have = 1'b0;
            m_hi   = 0;
            m_per  = 0;
        end else begin
            m_per++;
            if ($isunknown(ctrl)) begin
                checks++;
                errors++;
                $display("FAIL no_x: _control=%b required 0 or 1", ctrl);
            end
            if (ctrl === 1'b1) m_hi++;
            if (ctrl === 1'b1 && !m_prev) begin
                if (m_have) begin
                    checks++;
                    if (m_per !== F) begin
                        errors++;
                        $display("FAIL period: got %0d required %0d", m_per, F);
                    end
                end
                m_have = 1'b1;
                m_per  = 0;
            end
            if (ctrl === 1'b0 && m_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL width: got %0d, no pulse expected", m_hi);
                end else begin
                    e = exp_q.pop_front();
                    if (m_hi !== e) begin
                        errors++;
                        $display("FAIL width: got %0d required %0d", m_hi, e);
                    end
                end
                m_hi = 0;
            end
            m_prev = (ctrl === 1'b1);
        end
    end

    task automatic wait_rise();
        logic p;
        int   n;
        p = (ctrl === 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (!p && ctrl === 1'b1) return;
            p = (ctrl === 1'b1);
            if (n > 2 * F + 10) begin
                checks++;
                errors++;
                $display("FAIL wait_rise: no rising edge in %0d cycles", n);
                return;
            end
        end
    endtask

    task automatic wait_falls(input int cnt);
        logic p;
        int   n;
        for (int k = 0; k < cnt; k++) begin
            p = (ctrl === 1'b1);
            n = 0;
            forever begin
                @(negedge clk);
                n++;
                if (p && ctrl === 1'b0) break;
                p = (ctrl === 1'b1);
                if (n > 2 * F + 10) begin
                    checks++;
                    errors++;
                    $display("FAIL wait_fall: no falling edge in %0d cycles", n);
                    return;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pos   = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctrl !== 1'b0) begin
                errors++;
                $display("FAIL reset_low: got %b required 0", ctrl);
            end
        end
        rst_n = 1'b1;
        exp_q.push_back(P15);
        exp_q.push_back(P15);
        @(negedge clk);
        checks++;
        if (ctrl !== 1'b1) begin
            errors++;
            $display("FAIL first_rise: got %b required 1", ctrl);
        end
        wait_falls(2);
    endtask

    task automatic test_pos00();
        exp_q.push_back(exp_w(2'b01));
        wait_rise();
        pos = 2'b00;
        exp_q.push_back(P1);
        exp_q.push_back(P1);
        wait_falls(3);
    endtask

    task automatic test_pos11_10();
        exp_q.push_back(exp_w(2'b00));
        wait_rise();
        pos = 2'b11;
        exp_q.push_back(P15);
        wait_falls(2);
        exp_q.push_back(exp_w(2'b11));
        wait_rise();
        pos = 2'b10;
        exp_q.push_back(P2);
        wait_falls(2);
    endtask

    // Change at cnt=F-3 just makes the boundary; at cnt=F-2 it misses it.
    task automatic test_sync_edge();
        exp_q.push_back(P2);
        exp_q.push_back(P1);
        exp_q.push_back(P1);
        exp_q.push_back(P2);
        wait_rise();
        repeat (F - 4) @(negedge clk);
        pos = 2'b00;
        wait_rise();
        repeat (F - 3) @(negedge clk);
        pos = 2'b10;
        wait_falls(2);
    endtask

    task automatic test_midpulse();
        exp_q.push_back(P2);
        exp_q.push_back(P15);
        wait_rise();
        pos = 2'b01;
        wait_falls(2);
        exp_q.push_back(P15);
        exp_q.push_back(P2);
        wait_rise();
        repeat (24) @(negedge clk);
        checks++;
        if (ctrl !== 1'b1) begin
            errors++;
            $display("FAIL midpulse_high: got %b required 1", ctrl);
        end
        pos = 2'b10;
        wait_falls(2);
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(P2);
        wait_rise();
        pos = 2'b00;
        exp_q.push_back(P1);
        wait_falls(2);
        wait_rise();
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctrl !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_low: got %b required 0", ctrl);
            end
        end
        rst_n = 1'b1;
        exp_q.push_back(P15);
        exp_q.push_back(P1);
        @(negedge clk);
        checks++;
        if (ctrl !== 1'b1) begin
            errors++;
            $display("FAIL restart_rise: got %b required 1", ctrl);
        end
        wait_falls(2);
    endtask

    // Each position held 1.5 frames; frame j uses the last change before j*F.
    task automatic test_sequence();
        logic [1:0] seq [5];
        int idx;
        seq[0] = 2'b01;
        seq[1] = 2'b00;
        seq[2] = 2'b11;
        seq[3] = 2'b01;
        seq[4] = 2'b10;
        exp_q.push_back(P1);
        for (int j = 1; j <= 7; j++) begin
            idx = 0;
            while (idx < 4 && 3 * (idx + 1) < 2 * j) idx++;
            exp_q.push_back(exp_w(seq[idx]));
        end
        exp_q.push_back(P2);
        wait_rise();
        for (int i = 0; i < 5; i++) begin
            pos = seq[i];
            repeat (F * 3 / 2) @(negedge clk);
        end
        wait_falls(1);
    endtask

    initial begin
        test_reset();
        test_pos00();
        test_pos11_10();
        test_sync_edge();
        test_midpulse();
        test_reset_mid();
        test_sequence();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d pulses pending, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
